// File: rtl/dm_pkg.sv
// Shared encodings and FSM types for the data-memory responder.
package dm_pkg;
   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LB  = 3'b001;
   localparam logic [2:0] OP_LBU = 3'b010;
   localparam logic [2:0] OP_SW  = 3'b100;
   localparam logic [2:0] OP_SB  = 3'b101;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dm_lane.sv
// Combinational byte-lane datapath: store merge, load extract/extend, error decode.
module dm_lane
   import dm_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  lane,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] wr_word,
   output logic [31:0] rd_data,
   output logic        err
);
   logic [7:0] rd_byte;
   logic [3:0] be;

   assign rd_byte = old_word[{lane, 3'b000} +: 8];

   always_comb begin
      err = 1'b0;
      be  = 4'h0;
      case (op)
         OP_LW:         err = (lane != 2'b00);
         OP_SW: begin
            err = (lane != 2'b00);
            be  = 4'hF;
         end
         OP_SB:         be  = 4'b0001 << lane;
         OP_LB, OP_LBU: err = 1'b0;
         default:       err = 1'b1;
      endcase
   end

   // SW takes each byte from its own position; SB replicates wdata[7:0] into the enabled lane.
   for (genvar i = 0; i < 4; i++) begin : g_byte
      assign wr_word[8*i +: 8] = !be[i]       ? old_word[8*i +: 8] :
                                 (op == OP_SW) ? wdata[8*i +: 8]    : wdata[7:0];
   end

   always_comb begin
      rd_data = 32'h0;
      if (!err) begin
         case (op)
            OP_LW:   rd_data = old_word;
            OP_LB:   rd_data = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  rd_data = {24'h0, rd_byte};
            default: rd_data = 32'h0;
         endcase
      end
   end
endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: one request at a time, access after LATENCY wait cycles,
// response held until the initiator takes it.
module dm_resp
   import dm_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);
   localparam int DEPTH = 1 << (ADDR_W - 2);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       mem [DEPTH];
   logic [31:0]       old_word, wr_word, rd_data;
   logic              err, access, we;

   assign old_word = mem[addr_q[ADDR_W-1:2]];

   dm_lane u_lane (
      .op       (op_q),
      .lane     (addr_q[1:0]),
      .old_word (old_word),
      .wdata    (wdata_q),
      .wr_word  (wr_word),
      .rd_data  (rd_data),
      .err      (err)
   );

   assign access    = (state == WAIT) && (cnt == '0);
   assign we        = access && !err && ((op_q == OP_SW) || (op_q == OP_SB));
   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid) state_nx = WAIT;
         WAIT:    if (cnt == '0) state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         op_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= CNT_W'(LATENCY);
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (access) begin
            rsp_rdata <= rd_data;
            rsp_err   <= err;
         end
      end
   end

   // No reset on the array; a reset during WAIT forces IDLE so a pending store never lands.
   always_ff @(posedge clk) begin
      if (we) mem[addr_q[ADDR_W-1:2]] <= wr_word;
   end
endmodule

// File: tb/tb_dm_resp.sv
// Scoreboard bench for dm_resp: LATENCY=2 instance for function/backpressure/reset,
// LATENCY=0 instance for back-to-back throughput.
module tb_dm_resp;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err;
   logic [2:0]  req_op = 0;
   logic [11:0] req_addr = 0;
   logic [31:0] req_wdata = 0, rsp_rdata;

   logic        req_valid_z = 0, req_ready_z, rsp_valid_z, rsp_ready_z = 0, rsp_err_z;
   logic [2:0]  req_op_z = 0;
   logic [11:0] req_addr_z = 0;
   logic [31:0] req_wdata_z = 0, rsp_rdata_z;

   dm_resp #(.ADDR_W(12), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

   dm_resp #(.ADDR_W(12), .LATENCY(0)) u_dut_z (
      .clk(clk), .rst(rst), .req_valid(req_valid_z), .req_ready(req_ready_z),
      .req_op(req_op_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
      .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z));

   int nvec = 0;
   int nerr = 0;
   logic [32:0] exp_q[$];
   logic [31:0] mm [int];

   // Behavioural memory model; inst selects which DUT's storage is modelled.
   function automatic logic [32:0] model(input logic [2:0] op, input logic [11:0] a,
                                         input logic [31:0] wd, input int inst);
      int key;
      logic [31:0] w;
      logic [7:0] b;
      key = inst * 4096 + int'(a[11:2]);
      w = mm.exists(key) ? mm[key] : 32'h0;
      b = w[8*a[1:0] +: 8];
      case (op)
         3'b000: return (a[1:0] != 2'b00) ? {1'b1, 32'h0} : {1'b0, w};
         3'b001: return {1'b0, {24{b[7]}}, b};
         3'b010: return {1'b0, 24'h0, b};
         3'b100: begin
            if (a[1:0] != 2'b00) return {1'b1, 32'h0};
            mm[key] = wd;
            return 33'h0;
         end
         3'b101: begin
            w[8*a[1:0] +: 8] = wd[7:0];
            mm[key] = w;
            return 33'h0;
         end
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   // One request on the LATENCY=2 instance, with optional rsp_ready backpressure.
   task automatic issue(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                        input int hold);
      int n;
      logic [32:0] e;
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      nvec++;
      if (!req_ready) begin nerr++; $display("FAIL req_ready_timeout got=%b want=1", req_ready); end
      req_valid = 1; req_op = op; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      exp_q.push_back(model(op, a, wd, 0));
      req_valid = 0; req_op = 3'b000; req_addr = 12'hFFC; req_wdata = $urandom;
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      nvec++;
      if (n !== LAT + 1) begin nerr++; $display("FAIL latency op=%b got=%0d want=%0d", op, n, LAT + 1); end
      e = exp_q[0];
      for (int h = 0; h < hold; h++) begin
         nvec++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || {rsp_err, rsp_rdata} !== e) begin
            nerr++;
            $display("FAIL hold_stable cyc=%0d got v=%b r=%b %b/%h want v=1 r=0 %b/%h",
                     h, rsp_valid, req_ready, rsp_err, rsp_rdata, e[32], e[31:0]);
         end
         @(posedge clk); #1;
      end
      rsp_ready = 1;
      e = exp_q.pop_front();
      nvec++;
      if (rsp_rdata !== e[31:0]) begin nerr++; $display("FAIL rdata op=%b addr=%h got=%h want=%h", op, a, rsp_rdata, e[31:0]); end
      nvec++;
      if (rsp_err !== e[32]) begin nerr++; $display("FAIL err op=%b addr=%h got=%b want=%b", op, a, rsp_err, e[32]); end
      @(posedge clk); #1;
      rsp_ready = 0;
      nvec++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         nerr++; $display("FAIL release got req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {3'b100, 32'h0}) begin
         nerr++; $display("FAIL reset_state got rdy=%b v=%b e=%b d=%h want 1/0/0/0",
                          req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_store_load;
      issue(3'b100, 12'h010, 32'hDEADBEEF, 0);
      issue(3'b000, 12'h010, 32'h0, 0);
   endtask

   task automatic test_byte;
      issue(3'b100, 12'h010, 32'h11223344, 0);
      issue(3'b101, 12'h011, 32'hFFFFFF80, 0);
      issue(3'b000, 12'h010, 32'h0, 0);
      issue(3'b001, 12'h011, 32'h0, 0);
      issue(3'b010, 12'h011, 32'h0, 0);
      issue(3'b001, 12'h012, 32'h0, 0);
   endtask

   task automatic test_errors;
      issue(3'b000, 12'h012, 32'h0, 0);
      issue(3'b100, 12'h013, 32'hCAFEF00D, 0);
      issue(3'b000, 12'h010, 32'h0, 0);
      issue(3'b111, 12'h010, 32'h0, 0);
      issue(3'b011, 12'h014, 32'h0, 0);
   endtask

   task automatic test_backpressure;
      issue(3'b000, 12'h010, 32'h0, 5);
   endtask

   task automatic test_reset_mid;
      issue(3'b100, 12'h020, 32'h01234567, 0);
      issue(3'b000, 12'h020, 32'h0, 0);
      req_valid = 1; req_op = 3'b100; req_addr = 12'h020; req_wdata = 32'h5A5A5A5A;
      @(posedge clk); #1;
      req_valid = 0;
      #2 rst = 1;
      #1;
      nvec++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {3'b100, 32'h0}) begin
         nerr++; $display("FAIL async_reset got rdy=%b v=%b e=%b d=%h want 1/0/0/0",
                          req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
      repeat (2) @(posedge clk);
      #1 rst = 0;
      issue(3'b000, 12'h020, 32'h0, 0);
   endtask

   task automatic test_back_to_back;
      logic [2:0]  ops [4] = '{3'b100, 3'b100, 3'b000, 3'b000};
      logic [11:0] adr [4] = '{12'h000, 12'h004, 12'h000, 12'h004};
      logic [31:0] wds [4] = '{32'hA5A50F0F, 32'h13579BDF, 32'h0, 32'h0};
      int k, nrsp, last_acc;
      logic acc;
      logic [32:0] e;
      k = 0; nrsp = 0; last_acc = -10;
      rsp_ready_z = 1;
      req_valid_z = 1; req_op_z = ops[0]; req_addr_z = adr[0]; req_wdata_z = wds[0];
      for (int c = 0; c < 60 && nrsp < 4; c++) begin
         acc = req_ready_z && req_valid_z;
         if (rsp_valid_z) begin
            e = exp_q.pop_front();
            nvec++;
            if ({rsp_err_z, rsp_rdata_z} !== e) begin
               nerr++; $display("FAIL b2b_data n=%0d got %b/%h want %b/%h", nrsp, rsp_err_z, rsp_rdata_z, e[32], e[31:0]);
            end
            nvec++;
            if (c - last_acc !== 1) begin
               nerr++; $display("FAIL b2b_latency n=%0d got=%0d want=1", nrsp, c - last_acc);
            end
            nrsp++;
         end
         @(posedge clk); #1;
         if (acc) begin
            if (k > 0) begin
               nvec++;
               if (c + 1 - last_acc !== 3) begin
                  nerr++; $display("FAIL b2b_spacing k=%0d got=%0d want=3", k, c + 1 - last_acc);
               end
            end
            last_acc = c + 1;
            exp_q.push_back(model(ops[k], adr[k], wds[k], 1));
            k++;
            if (k < 4) begin req_op_z = ops[k]; req_addr_z = adr[k]; req_wdata_z = wds[k]; end
            else req_valid_z = 0;
         end
      end
      nvec++;
      if (nrsp !== 4) begin nerr++; $display("FAIL b2b_count got=%0d want=4", nrsp); end
      rsp_ready_z = 0;
   endtask

   initial begin
      test_reset;
      test_store_load;
      test_byte;
      test_errors;
      test_backpressure;
      test_reset_mid;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
